fifo16_ser_rd: RTL and testbench



---
 rtl/fifo16_ser_rd_pkg.sv | 12 +
 rtl/fifo16_ser_rd_strobe_div.sv | 27 ++
 rtl/fifo16_ser_rd.sv | 104 ++++++++++
 tb/tb_fifo16_ser_rd.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo16_ser_rd_pkg.sv
// Shared constants and state encoding for the FIFO serial read-side drain.
package fifo16_ser_rd_pkg;

  localparam int WORD_W   = 16;
  localparam int BITCNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/fifo16_ser_rd_strobe_div.sv
// Free-running divider: one-cycle strobe every DIV clocks, on terminal count.
module strobe_div #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic stb
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign stb = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (stb) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo16_ser_rd.sv
// FIFO read-side drain: one-word prefetch, MSB-first serializer with frame sync.
module fifo16_ser_rd
  import fifo16_ser_rd_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pdi,
  input  logic              empty,
  output logic              oe,
  output logic              sdo,
  output logic              fs,
  output logic              sclk_en,
  output logic              busy,
  output logic              underrun
);

  logic                stb;
  logic                rd;
  state_e              state_q;
  logic [WORD_W-1:0]   hreg_q;
  logic [WORD_W-1:0]   sreg_q;
  logic                hv_q;
  logic [BITCNT_W-1:0] bitcnt_q;
  logic                sdo_q, fs_q, sclk_en_q, busy_q, underrun_q;

  strobe_div #(.DIV(DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .stb (stb)
  );

  // Only ever one word ahead: request stops as soon as the holding register fills.
  assign oe = ~hv_q & ~rst;
  assign rd = oe & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hreg_q     <= '0;
      sreg_q     <= '0;
      hv_q       <= 1'b0;
      bitcnt_q   <= '0;
      sdo_q      <= 1'b0;
      fs_q       <= 1'b0;
      sclk_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sclk_en_q  <= stb;
      underrun_q <= 1'b0;
      // rd needs hv_q=0 and every transfer needs hv_q=1, so they never collide
      if (rd) begin
        hreg_q <= pdi;
        hv_q   <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (stb && hv_q) begin
            sreg_q   <= hreg_q;
            hv_q     <= 1'b0;
            bitcnt_q <= '1;
            fs_q     <= 1'b1;
            sdo_q    <= hreg_q[WORD_W-1];
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (stb) begin
            if (bitcnt_q != '0) begin
              sreg_q   <= sreg_q << 1;
              bitcnt_q <= bitcnt_q - 1'b1;
              fs_q     <= 1'b0;
              sdo_q    <= sreg_q[WORD_W-2];
            end else if (hv_q) begin
              // gapless reload of the prefetched word
              sreg_q   <= hreg_q;
              hv_q     <= 1'b0;
              bitcnt_q <= '1;
              fs_q     <= 1'b1;
              sdo_q    <= hreg_q[WORD_W-1];
            end else begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              underrun_q <= 1'b1;
              fs_q       <= 1'b0;
              sdo_q      <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sdo      = sdo_q;
  assign fs       = fs_q;
  assign sclk_en  = sclk_en_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_fifo16_ser_rd.sv
// Directed bench for fifo16_ser_rd: DIV=4 instance for timing, DIV=2 instance for stress.
module tb_fifo16_ser_rd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DIV=4 instance and its FIFO model
  logic [15:0] pdi4 = '0;
  logic        empty4 = 1'b1;
  logic        oe4, sdo4, fs4, sclk4, busy4, und4;
  logic        push4 = 1'b0;
  logic [15:0] pd4 = '0;
  logic [15:0] q4[$];
  int          pops4 = 0;

  // DIV=2 instance and its FIFO model
  logic [15:0] pdi2 = '0;
  logic        empty2 = 1'b1;
  logic        oe2, sdo2, fs2, sclk2, busy2, und2;
  logic        push2 = 1'b0;
  logic [15:0] pd2 = '0;
  logic [15:0] q2[$];
  logic [15:0] exp2[$];
  logic [15:0] rx2[$];

  fifo16_ser_rd #(.DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .pdi(pdi4), .empty(empty4), .oe(oe4),
    .sdo(sdo4), .fs(fs4), .sclk_en(sclk4), .busy(busy4), .underrun(und4)
  );

  fifo16_ser_rd #(.DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .pdi(pdi2), .empty(empty2), .oe(oe2),
    .sdo(sdo2), .fs(fs2), .sclk_en(sclk2), .busy(busy2), .underrun(und2)
  );

  always @(posedge clk) begin
    logic [15:0] tmp;
    if (oe4 && !empty4) begin
      tmp = q4.pop_front();
      pops4 <= pops4 + 1;
    end
    if (push4) q4.push_back(pd4);
    pdi4   <= (q4.size() > 0) ? q4[0] : 16'h0;
    empty4 <= (q4.size() == 0);
  end

  always @(posedge clk) begin
    logic [15:0] tmp;
    if (oe2 && !empty2) tmp = q2.pop_front();
    if (push2) q2.push_back(pd2);
    pdi2   <= (q2.size() > 0) ? q2[0] : 16'h0;
    empty2 <= (q2.size() == 0);
  end

  // Stream reassembly for the DIV=2 instance, framed by fs rising edges
  int          cyc2 = 0;
  logic        fs_prev2 = 1'b0;
  logic [15:0] wbuf2 = '0;
  always @(negedge clk) begin
    if (rst) begin
      cyc2 = 0;
    end else if (busy2) begin
      if (fs2 && !fs_prev2) cyc2 = 0;
      if ((cyc2 % 2) == 0) wbuf2 = {wbuf2[14:0], sdo2};
      cyc2++;
      if (cyc2 == 32) begin
        rx2.push_back(wbuf2);
        cyc2 = 0;
      end
    end
    fs_prev2 = fs2;
  end

  // Expected {busy, fs, sdo, underrun, sclk_en} at cycle j of a DIV=4 word
  function automatic logic [4:0] frame_exp(input logic [15:0] w, input int j);
    int b;
    b = 15 - j / 4;
    return {1'b1, (j < 4), w[b], 1'b0, ((j % 4) == 0)};
  endfunction

  logic [4:0] obs, exp;

  task automatic test_reset();
    push4 = 1'b1; pd4 = 16'hA5C3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push4 = 1'b0;
      checks++;
      if (oe4 !== 1'b0) begin
        failures++;
        $display("FAIL reset_oe cycle=%0d got=%b exp=0", k, oe4);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (oe4 !== 1'b1) begin
      failures++;
      $display("FAIL release_oe got=%b exp=1", oe4);
    end
    @(negedge clk);
    obs = {busy4, fs4, sdo4, und4, sclk4};
    checks++;
    if (obs !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", obs);
    end
  endtask

  task automatic test_single_word();
    for (int m = 2; m <= 69; m++) begin
      @(negedge clk);
      if (m >= 4 && m <= 67) exp = frame_exp(16'hA5C3, m - 4);
      else                   exp = {3'b000, (m == 68), ((m % 4) == 0)};
      obs = {busy4, fs4, sdo4, und4, sclk4};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL single m=%0d got=%b exp=%b", m, obs, exp);
      end
    end
    checks++;
    if (pops4 !== 1) begin
      failures++;
      $display("FAIL single_pops got=%0d exp=1", pops4);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[3];
    int p0;
    w[0] = 16'hFFFF; w[1] = 16'h0000; w[2] = 16'h8001;
    p0 = pops4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push4 = 1'b1; pd4 = w[k];
    end
    @(negedge clk);
    push4 = 1'b0;
    for (int k = 0; k < 20 && !busy4; k++) @(negedge clk);
    checks++;
    if (!busy4) begin
      failures++;
      $display("FAIL b2b_start_timeout got=0 exp=1");
      return;
    end
    for (int i = 0; i <= 192; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 192) exp = frame_exp(w[i / 64], i % 64);
      else         exp = 5'b00011;
      obs = {busy4, fs4, sdo4, und4, sclk4};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL b2b i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
    checks++;
    if (pops4 - p0 !== 3) begin
      failures++;
      $display("FAIL b2b_pops got=%0d exp=3", pops4 - p0);
    end
  endtask

  task automatic test_late_arrival();
    logic [15:0] wa, wb, wc;
    wa = 16'hC0DE; wb = 16'h7E81; wc = 16'h0F0F;
    @(negedge clk);
    push4 = 1'b1; pd4 = wa;
    @(negedge clk);
    push4 = 1'b0;
    for (int k = 0; k < 20 && !busy4; k++) @(negedge clk);
    checks++;
    if (!busy4) begin
      failures++;
      $display("FAIL late_start_timeout got=0 exp=1");
      return;
    end
    for (int i = 0; i <= 196; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 64)                 exp = frame_exp(wa, i);
      else if (i < 128)           exp = frame_exp(wb, i - 64);
      else if (i >= 132 && i < 196) exp = frame_exp(wc, i - 132);
      else                        exp = {3'b000, (i == 128 || i == 196), ((i % 4) == 0)};
      obs = {busy4, fs4, sdo4, und4, sclk4};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL late i=%0d got=%b exp=%b", i, obs, exp);
      end
      // wb lands 2 cycles before word A's last strobe, wc 1 cycle after word B's
      if (i == 60)  begin push4 = 1'b1; pd4 = wb; end
      if (i == 127) begin push4 = 1'b1; pd4 = wc; end
      if (i == 61 || i == 128) push4 = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    push4 = 1'b1; pd4 = 16'h1234;
    @(negedge clk);
    push4 = 1'b0;
    for (int k = 0; k < 20 && !busy4; k++) @(negedge clk);
    checks++;
    if (!busy4) begin
      failures++;
      $display("FAIL midrst_start_timeout got=0 exp=1");
      return;
    end
    for (int i = 0; i <= 33; i++) begin
      if (i > 0) @(negedge clk);
      exp = frame_exp(16'h1234, i);
      obs = {busy4, fs4, sdo4, und4, sclk4};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL midrst_pre i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
    rst = 1'b1; push4 = 1'b1; pd4 = 16'h5678;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      push4 = 1'b0;
      obs = {busy4, fs4, sdo4, und4, sclk4};
      checks++;
      if (obs !== 5'b0 || oe4 !== 1'b0) begin
        failures++;
        $display("FAIL midrst_reset k=%0d got=%b oe=%b exp=00000 oe=0", k, obs, oe4);
      end
    end
    rst = 1'b0;
    for (int m = 1; m <= 69; m++) begin
      @(negedge clk);
      if (m >= 4 && m <= 67) exp = frame_exp(16'h5678, m - 4);
      else                   exp = {3'b000, (m == 68), ((m % 4) == 0)};
      obs = {busy4, fs4, sdo4, und4, sclk4};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL midrst_post m=%0d got=%b exp=%b", m, obs, exp);
      end
    end
  endtask

  task automatic test_div2_stress();
    int gap;
    for (int n = 0; n < 200; n++) begin
      for (int k = 0; k < 200 && q2.size() >= 13; k++) @(negedge clk);
      push2 = 1'b1;
      pd2 = 16'($urandom());
      exp2.push_back(pd2);
      @(negedge clk);
      push2 = 1'b0;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) @(negedge clk);
    end
    for (int k = 0; k < 3000 && rx2.size() < 200; k++) @(negedge clk);
    checks++;
    if (rx2.size() !== 200) begin
      failures++;
      $display("FAIL stress_count got=%0d exp=200", rx2.size());
    end
    for (int n = 0; n < 200 && n < rx2.size(); n++) begin
      checks++;
      if (rx2[n] !== exp2[n]) begin
        failures++;
        $display("FAIL stress_word n=%0d got=%h exp=%h", n, rx2[n], exp2[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_late_arrival();
    test_mid_reset();
    test_div2_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
